// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-drain PS/2 pin bundle for ps2_host_tx
//   send/cmd          request and command byte from the controller
//   busy/done         transfer in progress / one-cycle end-of-transfer pulse
//   ack_ok/timeout    transfer result, held until the next accepted send
//   ps2_*_in          raw pin levels, ps2_*_drive_low  1 = pull pin low
interface ps2_host_tx_if;
  logic       send;
  logic [7:0] cmd;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       timeout;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  modport master (
    output send, cmd, ps2_clk_in, ps2_data_in,
    input  busy, done, ack_ok, timeout, ps2_clk_drive_low, ps2_data_drive_low
  );
  modport slave (
    input  send, cmd, ps2_clk_in, ps2_data_in,
    output busy, done, ack_ok, timeout, ps2_clk_drive_low, ps2_data_drive_low
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, request-to-send, frame, acknowledge)
//   clk    system clock
//   reset  asynchronous active-low reset; releases both pins immediately
//   bus    ps2_host_tx_if.slave: send/cmd in, busy/done/ack_ok/timeout out, ps2 pins
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input logic          clk,
  input logic          reset,
  ps2_host_tx_if.slave bus
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] sh, sh_n;
  logic [3:0] bits, bits_n;
  logic data_low, data_low_n;
  logic ack_s, ack_s_n;
  logic ack_ok_q, ack_ok_n;
  logic timeout_q, timeout_n;
  logic clk_s1, clk_s2, clk_prev, data_s1, data_s2, fall;
  // synchronizers idle high so reset release never looks like a falling edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {clk_s1, clk_s2, clk_prev, data_s1, data_s2} <= '1;
      fall <= 1'b0;
    end else begin
      clk_s1 <= bus.ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_prev <= clk_s2;
      data_s1 <= bus.ps2_data_in;
      data_s2 <= data_s1;
      fall <= clk_prev & ~clk_s2;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      bits <= '0;
      data_low <= 1'b0;
      ack_s <= 1'b0;
      ack_ok_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      bits <= bits_n;
      data_low <= data_low_n;
      ack_s <= ack_s_n;
      ack_ok_q <= ack_ok_n;
      timeout_q <= timeout_n;
    end
  // sh holds {stop, odd parity, cmd} and shifts out LSB first, one bit per device falling edge
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    bits_n = bits;
    data_low_n = data_low;
    ack_s_n = ack_s;
    ack_ok_n = ack_ok_q;
    timeout_n = timeout_q;
    unique case (state)
      IDLE:
        if (bus.send) begin
          state_n = INHIBIT;
          cnt_n = '0;
          sh_n = {1'b1, ~^bus.cmd, bus.cmd};
          data_low_n = 1'b0;
          ack_ok_n = 1'b0;
          timeout_n = 1'b0;
        end
      INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n = RTS;
          data_low_n = 1'b1;
        end
      end
      RTS: begin
        state_n = SEND;
        cnt_n = '0;
        bits_n = '0;
      end
      SEND, ACK: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_n = FIN;
          data_low_n = 1'b0;
          timeout_n = 1'b1;
          ack_ok_n = 1'b0;
        end else if (fall && state == SEND) begin
          data_low_n = ~sh[0];
          sh_n = sh >> 1;
          bits_n = bits + 1'b1;
          state_n = bits == 4'd9 ? ACK : SEND;
        end else if (fall) begin
          ack_s_n = ~data_s2;
          state_n = WAIT_IDLE;
        end
      end
      // the acknowledge result is only published together with done
      WAIT_IDLE:
        if (clk_s2 & data_s2) begin
          state_n = FIN;
          ack_ok_n = ack_s;
        end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.ps2_clk_drive_low = state == INHIBIT || state == RTS;
  assign bus.ps2_data_drive_low = data_low;
  assign bus.busy = state != IDLE;
  assign bus.done = state == FIN;
  assign bus.ack_ok = ack_ok_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model and a per-cycle behavioural reference
module tb_ps2_host_tx;
  localparam int INH = 5000;
  localparam int TMO = 1000;
  logic clk = 0;
  logic reset = 0;
  logic dev_clk = 1;
  logic dev_data = 1;
  ps2_host_tx_if bus();
  assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_drive_low;
  assign bus.ps2_data_in = dev_data & ~bus.ps2_data_drive_low;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // pre-edge view of inputs and pins: stimulus only changes on negedge
  logic p_send = 0, p_c = 1, p_d = 1;
  logic [7:0] p_cmd = 0;
  always @(negedge clk) begin
    #1;
    p_send = bus.send;
    p_cmd = bus.cmd;
    p_c = bus.ps2_clk_in;
    p_d = bus.ps2_data_in;
  end
  // reference: t = cycles since acceptance, edges = device falling edges seen after release,
  // a pin fall first sampled at edge E takes effect at edge E+3; synced data lags the pin by 2
  logic m_on = 0, m_fin = 0, m_wait = 0, m_ack = 0, m_to = 0, m_acks = 0;
  int m_t = 0, m_tc = 0, m_edges = 0;
  logic [9:0] m_frame = 0;
  logic [4:0] hc = '1, hd = '1;
  logic m_fall, e_clk, e_data;
  int cyc = 0, done_cnt = 0, cl_rise = 0, dl_rise = 0, cl_len = 0, rel_cyc = 0, done_cyc = 0;
  logic prev_cl = 0, prev_dl = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      m_on = 0; m_fin = 0; m_wait = 0; m_ack = 0; m_to = 0;
      hc = '1; hd = '1;
    end else begin
      hc = {hc[3:0], p_c};
      hd = {hd[3:0], p_d};
      m_fall = hc[4] && !hc[3];
      if (m_fin) begin
        m_on = 0; m_fin = 0;
      end else if (!m_on) begin
        if (p_send) begin
          m_on = 1; m_t = 0; m_wait = 0; m_edges = 0; m_ack = 0; m_to = 0;
          m_frame = {1'b1, ($countones(p_cmd) % 2 == 0), p_cmd};
        end
      end else begin
        m_t++;
        if (m_t == INH + 1) begin
          m_tc = 0; m_edges = 0;
        end else if (m_wait) begin
          if (hc[2] && hd[2]) begin m_fin = 1; m_ack = m_acks; end
        end else if (m_t > INH + 1) begin
          if (m_tc == TMO - 1) begin
            m_fin = 1; m_to = 1; m_ack = 0;
          end else begin
            m_tc++;
            if (m_fall) begin
              m_edges++;
              if (m_edges == 11) begin m_acks = !hd[2]; m_wait = 1; end
            end
          end
        end
      end
      e_clk = m_on && !m_fin && m_t <= INH;
      e_data = 0;
      if (m_on && !m_fin && !m_wait) begin
        if (m_t == INH) e_data = 1;
        else if (m_t > INH) e_data = (m_edges == 0) ? 1'b1 : !m_frame[m_edges-1];
      end
      chk("busy", bus.busy, m_on);
      chk("done", bus.done, m_fin);
      chk("clk_drive_low", bus.ps2_clk_drive_low, e_clk);
      chk("data_drive_low", bus.ps2_data_drive_low, e_data);
      chk("ack_ok", bus.ack_ok, m_ack);
      chk("timeout", bus.timeout, m_to);
      if (bus.ps2_clk_drive_low && !prev_cl) cl_rise = cyc;
      if (!bus.ps2_clk_drive_low && prev_cl) begin cl_len = cyc - cl_rise; rel_cyc = cyc; end
      if (bus.ps2_data_drive_low && !prev_dl && bus.ps2_clk_drive_low) dl_rise = cyc;
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      prev_cl = bus.ps2_clk_drive_low;
      prev_dl = bus.ps2_data_drive_low;
    end
  end
  task automatic start(input logic [7:0] c);
    bus.send = 1;
    bus.cmd = c;
    @(negedge clk);
    bus.send = 0;
  endtask
  // device: wait for release, then nclk clock pulses; samples data before each rising edge
  task automatic device(input int nclk, input logic ack, output logic [9:0] rx);
    int n;
    rx = '0;
    n = 0;
    while (bus.ps2_clk_drive_low && n < INH + 100) begin @(negedge clk); n++; end
    chk("release_seen", bus.ps2_clk_drive_low, 0);
    repeat (20) @(negedge clk);
    chk("start_bit", bus.ps2_data_in, 0);
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) dev_data = 0;
      dev_clk = 0;
      repeat (30) @(negedge clk);
      if (i < 10) rx[i] = bus.ps2_data_in;
      dev_clk = 1;
      repeat (30) @(negedge clk);
      dev_data = 1;
    end
  endtask
  task automatic finish_xfer(input int d0, input logic exp_ack, input logic exp_to);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 8000) begin @(negedge clk); n++; end
    chk("done_pulse_count", done_cnt, d0 + 1);
    n = 0;
    while (bus.busy && n < 20) begin @(negedge clk); n++; end
    chk("busy_dropped", bus.busy, 0);
    chk("result_ack_ok", bus.ack_ok, exp_ack);
    chk("result_timeout", bus.timeout, exp_to);
    chk("drives_released", {bus.ps2_clk_drive_low, bus.ps2_data_drive_low}, 0);
  endtask
  task automatic run(input logic [7:0] c, input int nclk, input logic ack,
                     input logic [9:0] exp_rx, input logic exp_ack, input logic exp_to);
    int d0;
    logic [9:0] rx;
    d0 = done_cnt;
    start(c);
    device(nclk, ack, rx);
    if (nclk == 11) chk("device_rx", rx, exp_rx);
    finish_xfer(d0, exp_ack, exp_to);
  endtask
  initial begin
    int d0;
    logic [9:0] rx;
    bus.send = 0;
    bus.cmd = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ack_ok", bus.ack_ok, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_clk_drive", bus.ps2_clk_drive_low, 0);
    chk("rst_data_drive", bus.ps2_data_drive_low, 0);
    reset = 1;
    repeat (3) @(negedge clk);
    run(8'hED, 11, 1, 10'h3ED, 1, 0);
    chk("inhibit_len", cl_len, INH + 1);
    chk("rts_offset", dl_rise - cl_rise, INH);
    run(8'h00, 11, 1, 10'h300, 1, 0);
    run(8'hFF, 11, 1, 10'h3FF, 1, 0);
    run(8'h01, 11, 1, 10'h201, 1, 0);
    run(8'hF0, 11, 0, 10'h3F0, 0, 0);
    run(8'h55, 0, 0, 10'h000, 0, 1);
    chk("timeout_latency", done_cyc - rel_cyc, TMO);
    d0 = done_cnt;
    start(8'hED);
    fork
      device(11, 1, rx);
      begin
        repeat (200) @(negedge clk);
        start(8'h12);
        repeat (5200) @(negedge clk);
        start(8'h12);
      end
    join
    chk("ignored_send_rx", rx, 10'h3ED);
    finish_xfer(d0, 1, 0);
    repeat (50) @(negedge clk);
    chk("single_done", done_cnt, d0 + 1);
    start(8'hED);
    device(4, 0, rx);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    reset = 0;
    #1;
    chk("async_rst_drives", {bus.ps2_clk_drive_low, bus.ps2_data_drive_low}, 0);
    chk("async_rst_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);
    run(8'hF4, 11, 1, 10'h2F4, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
